// File: rtl/instruction_loader_if.sv
// Host-to-loader bundle: load command, halfword stream and the four
// instruction-memory write lanes.
//   master : host side (drives command + stream, observes lanes/status)
//   slave  : instruction_loader (accepts command + stream, drives lanes/status)
interface instruction_loader_if #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  load_start;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [ADDR_WIDTH-1:0] load_count;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  logic [ADDR_WIDTH-1:0] instruction_wr1;
  logic [ADDR_WIDTH-1:0] instruction_wr2;
  logic [ADDR_WIDTH-1:0] instruction_wr3;
  logic [ADDR_WIDTH-1:0] instruction_wr4;
  logic [DATA_WIDTH-1:0] instruction_wr1_data;
  logic [DATA_WIDTH-1:0] instruction_wr2_data;
  logic [DATA_WIDTH-1:0] instruction_wr3_data;
  logic [DATA_WIDTH-1:0] instruction_wr4_data;
  logic                  instruction_wr1_enable;
  logic                  instruction_wr2_enable;
  logic                  instruction_wr3_enable;
  logic                  instruction_wr4_enable;

  logic                  busy;
  logic                  done;

  modport master (
    output load_start, load_addr, load_count, in_data, in_valid,
    input  in_ready,
    input  instruction_wr1, instruction_wr2, instruction_wr3, instruction_wr4,
    input  instruction_wr1_data, instruction_wr2_data,
    input  instruction_wr3_data, instruction_wr4_data,
    input  instruction_wr1_enable, instruction_wr2_enable,
    input  instruction_wr3_enable, instruction_wr4_enable,
    input  busy, done
  );

  modport slave (
    input  load_start, load_addr, load_count, in_data, in_valid,
    output in_ready,
    output instruction_wr1, instruction_wr2, instruction_wr3, instruction_wr4,
    output instruction_wr1_data, instruction_wr2_data,
    output instruction_wr3_data, instruction_wr4_data,
    output instruction_wr1_enable, instruction_wr2_enable,
    output instruction_wr3_enable, instruction_wr4_enable,
    output busy, done
  );
endinterface

// File: rtl/instruction_loader.sv
// Instruction memory loader: takes a start address and halfword count,
// accepts a valid/ready halfword stream, packs up to four halfwords per
// group and writes each group in one cycle on the four write lanes.
// Holds the processor (busy) for the whole load.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : instruction_loader_if.slave (command, stream, write lanes, busy/done)
module instruction_loader #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  instruction_loader_if.slave   bus
);

  localparam int unsigned LANES  = 4;
  localparam int unsigned FILL_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_remaining;
  logic [FILL_W-1:0]     r_fill_idx;
  logic [DATA_WIDTH-1:0] r_buf [LANES];

  logic                  w_accept;
  logic [FILL_W-1:0]     w_fill_next;
  logic [DATA_WIDTH-1:0] w_buf_next [LANES];

  logic [ADDR_WIDTH-1:0] w_wr_addr [LANES];
  logic [DATA_WIDTH-1:0] w_wr_data [LANES];
  logic [LANES-1:0]      w_wr_en;
  logic                  w_in_ready;
  logic                  w_busy;
  logic                  w_done;

  logic [ADDR_WIDTH-1:0] r_wr_addr [LANES];
  logic [DATA_WIDTH-1:0] r_wr_data [LANES];
  logic [LANES-1:0]      r_wr_en;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_done;

  // in_ready is high exactly while in FILL, so FILL alone qualifies a handshake
  assign w_accept = (r_state == S_FILL) && bus.in_valid;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.load_start)
          w_state_next = (bus.load_count == '0) ? S_DONE : S_FILL;
      end
      S_FILL: begin
        // group closes on slot 3 or on the last halfword of the load
        if (w_accept && ((r_fill_idx == FILL_W'(3)) || (r_remaining == ADDR_WIDTH'(1))))
          w_state_next = S_WRITE;
      end
      S_WRITE: w_state_next = (r_remaining != '0) ? S_FILL : S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Buffer/fill view including the halfword accepted this cycle
  always_comb begin
    for (int i = 0; i < LANES; i++) w_buf_next[i] = r_buf[i];
    w_fill_next = r_fill_idx;
    if (w_accept) begin
      w_buf_next[r_fill_idx[1:0]] = bus.in_data;
      w_fill_next                 = r_fill_idx + FILL_W'(1);
    end
  end

  // Output logic: next values for the registered outputs
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_wr_addr[k] = '0;
      w_wr_data[k] = '0;
    end
    w_wr_en    = '0;
    w_in_ready = (w_state_next == S_FILL);
    w_busy     = (w_state_next != S_IDLE);
    w_done     = (w_state_next == S_DONE);
    // WRITE is only entered from FILL, so r_base is still the group base here
    if (w_state_next == S_WRITE) begin
      for (int k = 0; k < LANES; k++) begin
        if (FILL_W'(k) < w_fill_next) begin
          w_wr_addr[k] = r_base + ADDR_WIDTH'(k);
          w_wr_data[k] = w_buf_next[k];
          w_wr_en[k]   = 1'b1;
        end
      end
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < LANES; k++) begin
        r_wr_addr[k] <= '0;
        r_wr_data[k] <= '0;
      end
      r_wr_en    <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        r_wr_addr[k] <= w_wr_addr[k];
        r_wr_data[k] <= w_wr_data[k];
      end
      r_wr_en    <= w_wr_en;
      r_in_ready <= w_in_ready;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  // Load datapath: base address, halfwords left, group buffer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_base      <= '0;
      r_remaining <= '0;
      r_fill_idx  <= '0;
      for (int i = 0; i < LANES; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.load_start) begin
            r_base      <= bus.load_addr;
            r_remaining <= bus.load_count;
            r_fill_idx  <= '0;
          end
        end
        S_FILL: begin
          if (w_accept) begin
            for (int i = 0; i < LANES; i++) r_buf[i] <= w_buf_next[i];
            r_fill_idx  <= w_fill_next;
            r_remaining <= r_remaining - ADDR_WIDTH'(1);
          end
        end
        S_WRITE: begin
          r_base     <= r_base + ADDR_WIDTH'(LANES);
          r_fill_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready               = r_in_ready;
  assign bus.busy                   = r_busy;
  assign bus.done                   = r_done;
  assign bus.instruction_wr1        = r_wr_addr[0];
  assign bus.instruction_wr2        = r_wr_addr[1];
  assign bus.instruction_wr3        = r_wr_addr[2];
  assign bus.instruction_wr4        = r_wr_addr[3];
  assign bus.instruction_wr1_data   = r_wr_data[0];
  assign bus.instruction_wr2_data   = r_wr_data[1];
  assign bus.instruction_wr3_data   = r_wr_data[2];
  assign bus.instruction_wr4_data   = r_wr_data[3];
  assign bus.instruction_wr1_enable = r_wr_en[0];
  assign bus.instruction_wr2_enable = r_wr_en[1];
  assign bus.instruction_wr3_enable = r_wr_en[2];
  assign bus.instruction_wr4_enable = r_wr_en[3];

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed loads, an
// expected-event model (write groups then a done pulse) checked every cycle,
// plus literal checks on the key cycles.
module tb_instruction_loader;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  instruction_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instruction_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit                    is_done;
    logic [3:0]            en;
    logic [3:0][AW-1:0]    addr;
    logic [3:0][DW-1:0]    data;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected events for one load: groups of up to four consecutive addresses
  function automatic void model_load(logic [AW-1:0] addr, int count, logic [DW-1:0] hw[$]);
    ev_t e;
    int idx = 0;
    logic [AW-1:0] base = addr;
    while (idx < count) begin
      e.is_done = 1'b0;
      e.en      = '0;
      e.addr    = '0;
      e.data    = '0;
      for (int k = 0; k < 4; k++) begin
        if (idx < count) begin
          e.en[k]   = 1'b1;
          e.addr[k] = base + AW'(k);
          e.data[k] = hw[idx];
          idx++;
        end
      end
      exp_q.push_back(e);
      base = base + AW'(4);
    end
    e.is_done = 1'b1;
    e.en      = '0;
    e.addr    = '0;
    e.data    = '0;
    exp_q.push_back(e);
  endfunction

  // Every cycle: any write or done must be the next expected event
  always @(negedge clock) begin
    logic [3:0]         en;
    logic [3:0][AW-1:0] la;
    logic [3:0][DW-1:0] ld;
    ev_t                e;
    if (reset) begin
      en = {bus.instruction_wr4_enable, bus.instruction_wr3_enable,
            bus.instruction_wr2_enable, bus.instruction_wr1_enable};
      la = {bus.instruction_wr4, bus.instruction_wr3, bus.instruction_wr2, bus.instruction_wr1};
      ld = {bus.instruction_wr4_data, bus.instruction_wr3_data,
            bus.instruction_wr2_data, bus.instruction_wr1_data};
      if ((en != 4'b0) || bus.done) begin
        if (exp_q.size() == 0) begin
          check("stray_event", {27'b0, en, bus.done}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("ev_done", {31'b0, bus.done}, {31'b0, e.is_done});
          check("ev_en", {28'b0, en}, {28'b0, e.en});
          for (int k = 0; k < 4; k++) begin
            check($sformatf("ev_addr%0d", k + 1), {12'b0, la[k]}, {12'b0, e.addr[k]});
            check($sformatf("ev_data%0d", k + 1), {16'b0, ld[k]}, {16'b0, e.data[k]});
          end
        end
      end
    end
  end

  task automatic start_load(logic [AW-1:0] addr, int count);
    @(posedge clock); #1;
    bus.load_start = 1'b1;
    bus.load_addr  = addr;
    bus.load_count = AW'(count);
    @(posedge clock); #1;
    bus.load_start = 1'b0;
  endtask

  task automatic send_hw(logic [DW-1:0] d, int gap);
    int  t  = 0;
    bit  ok = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!ok && t < 50) begin
      @(negedge clock);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clock); #1;
      t++;
    end
    bus.in_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_idle(string name);
    int t = 0;
    @(negedge clock);
    while (bus.busy && t < 50) begin @(negedge clock); t++; end
    check({name, "_idle"}, {31'b0, bus.busy}, 32'h0);
    check({name, "_drained"}, exp_q.size(), 32'h0);
  endtask

  function automatic logic [3:0] enables();
    return {bus.instruction_wr4_enable, bus.instruction_wr3_enable,
            bus.instruction_wr2_enable, bus.instruction_wr1_enable};
  endfunction

  initial begin
    logic [DW-1:0] hw[$];
    bus.load_start = 1'b0;
    bus.load_addr  = '0;
    bus.load_count = '0;
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;

    // Reset state
    @(posedge clock); #1;
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'h0);
    check("rst_done", {31'b0, bus.done}, 32'h0);
    check("rst_en", {28'b0, enables()}, 32'h0);
    check("rst_wr1", {12'b0, bus.instruction_wr1}, 32'h0);
    check("rst_wr4_data", {16'b0, bus.instruction_wr4_data}, 32'h0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Aligned group
    hw = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    model_load(20'h00010, 4, hw);
    start_load(20'h00010, 4);
    check("al_start_busy", {31'b0, bus.busy}, 32'h1);
    check("al_start_ready", {31'b0, bus.in_ready}, 32'h1);
    foreach (hw[i]) send_hw(hw[i], 0);
    @(negedge clock);
    check("al_en", {28'b0, enables()}, 32'hF);
    check("al_wr1", {12'b0, bus.instruction_wr1}, 32'h00010);
    check("al_wr4", {12'b0, bus.instruction_wr4}, 32'h00013);
    check("al_wr1_data", {16'b0, bus.instruction_wr1_data}, 32'h1111);
    check("al_wr4_data", {16'b0, bus.instruction_wr4_data}, 32'h4444);
    check("al_ready_in_write", {31'b0, bus.in_ready}, 32'h0);
    @(negedge clock);
    check("al_done", {31'b0, bus.done}, 32'h1);
    check("al_done_busy", {31'b0, bus.busy}, 32'h1);
    check("al_done_en", {28'b0, enables()}, 32'h0);
    @(negedge clock);
    check("al_done_once", {31'b0, bus.done}, 32'h0);
    check("al_busy_fall", {31'b0, bus.busy}, 32'h0);
    wait_idle("aligned");

    // Partial tail
    hw = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'hA006};
    model_load(20'h00010, 6, hw);
    start_load(20'h00010, 6);
    foreach (hw[i]) send_hw(hw[i], 0);
    @(negedge clock);
    check("pt_en", {28'b0, enables()}, 32'h3);
    check("pt_wr1", {12'b0, bus.instruction_wr1}, 32'h00014);
    check("pt_wr2", {12'b0, bus.instruction_wr2}, 32'h00015);
    check("pt_wr3_zero", {12'b0, bus.instruction_wr3}, 32'h0);
    wait_idle("partial");

    // Wrap
    hw = '{16'hB001, 16'hB002, 16'hB003, 16'hB004};
    model_load(20'hFFFFE, 4, hw);
    start_load(20'hFFFFE, 4);
    foreach (hw[i]) send_hw(hw[i], 0);
    @(negedge clock);
    check("wr_wr1", {12'b0, bus.instruction_wr1}, 32'hFFFFE);
    check("wr_wr2", {12'b0, bus.instruction_wr2}, 32'hFFFFF);
    check("wr_wr3", {12'b0, bus.instruction_wr3}, 32'h00000);
    check("wr_wr4", {12'b0, bus.instruction_wr4}, 32'h00001);
    wait_idle("wrap");

    // Zero count
    hw = {};
    model_load(20'h00040, 0, hw);
    start_load(20'h00040, 0);
    check("zc_done", {31'b0, bus.done}, 32'h1);
    check("zc_busy", {31'b0, bus.busy}, 32'h1);
    check("zc_ready", {31'b0, bus.in_ready}, 32'h0);
    @(posedge clock); #1;
    check("zc_done_clear", {31'b0, bus.done}, 32'h0);
    check("zc_idle", {31'b0, bus.busy}, 32'h0);
    check("zc_ready2", {31'b0, bus.in_ready}, 32'h0);
    wait_idle("zero");

    // Stalls between halfwords
    hw = '{16'hC001, 16'hC002, 16'hC003};
    model_load(20'h00100, 3, hw);
    start_load(20'h00100, 3);
    send_hw(hw[0], 0);
    send_hw(hw[1], 2);
    send_hw(hw[2], 2);
    wait_idle("stall");

    // Second load_start during FILL is ignored
    hw = '{16'hD001, 16'hD002, 16'hD003, 16'hD004};
    model_load(20'h00200, 4, hw);
    start_load(20'h00200, 4);
    send_hw(hw[0], 0);
    bus.load_start = 1'b1;
    bus.load_addr  = 20'h00300;
    bus.load_count = AW'(2);
    @(posedge clock); #1;
    bus.load_start = 1'b0;
    send_hw(hw[1], 0);
    send_hw(hw[2], 0);
    send_hw(hw[3], 0);
    wait_idle("busyprot");
    repeat (3) @(negedge clock);
    check("busyprot_stays_idle", {31'b0, bus.busy}, 32'h0);

    // Reset mid-load
    start_load(20'h00020, 4);
    send_hw(16'hE001, 0);
    send_hw(16'hE002, 0);
    reset = 1'b0;
    #1;
    check("mr_busy", {31'b0, bus.busy}, 32'h0);
    check("mr_ready", {31'b0, bus.in_ready}, 32'h0);
    check("mr_done", {31'b0, bus.done}, 32'h0);
    check("mr_en", {28'b0, enables()}, 32'h0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hE003;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      check("mr_after_busy", {31'b0, bus.busy}, 32'h0);
      check("mr_after_en", {28'b0, enables()}, 32'h0);
    end
    bus.in_valid = 1'b0;

    // Recovery load after reset
    hw = '{16'hF001, 16'hF002};
    model_load(20'h00030, 2, hw);
    start_load(20'h00030, 2);
    foreach (hw[i]) send_hw(hw[i], 0);
    wait_idle("recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
